// File: rtl/add_serial_arb_pkg.sv
// Shared types and constants for the serial-adder arbiter.
// Build option: ADD_SERIAL_ARB_PRIO_EN selects fixed priority.
package add_serial_arb_pkg;

    localparam int W          = 8;
    localparam int ADD_CYCLES = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/add_serial_arb_rr_pick.sv
// Combinational rotating picker: first requester at or after ptr_i.
// With ptr_i tied to zero it degenerates to lowest-index priority.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_o && req_i[(int'(ptr_i) + k) % NREQ]) begin
                any_o = 1'b1;
                idx_o = IW'((int'(ptr_i) + k) % NREQ);
            end
        end
        if (any_o) begin
            gnt_o = NREQ'(1) << idx_o;
        end
    end

endmodule

// File: rtl/add_serial_arb.sv
// Shares one serial adder among NREQ requesters, counting its busy cycles.
// ADD_SERIAL_ARB_PRIO_EN: fixed priority (lowest index) instead of round robin.
module add_serial_arb #(
    parameter int NREQ       = 4,
    parameter int W          = add_serial_arb_pkg::W,
    parameter int ADD_CYCLES = add_serial_arb_pkg::ADD_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_sum,
    output logic              busy,
    output logic              add_en,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W-1:0]      add_out
);

    import add_serial_arb_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_sum_q, rsp_sum_d;
    logic [IW-1:0]   ptr;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

`ifdef ADD_SERIAL_ARB_PRIO_EN
    assign ptr = '0;
`else
    logic [IW-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = '0;
        rsp_sum_d   = rsp_sum_q;
        req_ready   = '0;
`ifndef ADD_SERIAL_ARB_PRIO_EN
        ptr_d       = ptr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    req_ready = pick_gnt;
                    idx_d     = pick_idx;
                    a_d       = req_a[int'(pick_idx)*W +: W];
                    b_d       = req_b[int'(pick_idx)*W +: W];
                    state_d   = S_LOAD;
`ifndef ADD_SERIAL_ARB_PRIO_EN
                    ptr_d = (pick_idx == IW'(NREQ-1)) ?
                            '0 : pick_idx + IW'(1);
`endif
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            // The adder has no done flag; its ADD phase length is fixed.
            S_RUN: begin
                if (cnt_q == CW'(ADD_CYCLES-1)) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                rsp_sum_d   = add_out;
                rsp_valid_d = NREQ'(1) << idx_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
`ifndef ADD_SERIAL_ARB_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
`ifndef ADD_SERIAL_ARB_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign add_en    = (state_q == S_LOAD);
    assign add_a     = a_q;
    assign add_b     = b_q;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_add_serial_arb.sv
// Scoreboard bench for add_serial_arb with a bit-serial adder model.
// Expected grant orders follow ADD_SERIAL_ARB_PRIO_EN when defined.
module tb_add_serial_arb;

    localparam int N = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*8-1:0] req_a;
    logic [N*8-1:0] req_b;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [7:0]    rsp_sum;
    logic          busy;
    logic          add_en;
    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic [7:0]    add_out;

    add_serial_arb #(.NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .busy      (busy),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bit-serial adder: IDLE -> 8 x ADD (one bit each) -> DONE until en low.
    logic [1:0] ad_st;
    logic [7:0] ad_a, ad_b, ad_out;
    logic       ad_c;
    logic [2:0] ad_n;
    logic [1:0] ad_s;
    assign ad_s = {1'b0, ad_a[ad_n]} + {1'b0, ad_b[ad_n]} + {1'b0, ad_c};
    assign add_out = ad_out;

    always @(posedge clk) begin
        if (rst) begin
            ad_st <= 2'd0; ad_a <= '0; ad_b <= '0;
            ad_out <= '0; ad_c <= 1'b0; ad_n <= '0;
        end else begin
            case (ad_st)
                2'd0: if (add_en) begin
                    ad_a <= add_a; ad_b <= add_b; ad_out <= '0;
                    ad_c <= 1'b0; ad_n <= '0; ad_st <= 2'd1;
                end
                2'd1: begin
                    ad_out[ad_n] <= ad_s[0];
                    ad_c <= ad_s[1];
                    ad_n <= ad_n + 3'd1;
                    if (ad_n == 3'd7) ad_st <= 2'd2;
                end
                default: if (!add_en) ad_st <= 2'd0;
            endcase
        end
    end

    typedef struct {
        int         idx;
        logic [7:0] sum;
        int         due;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         exp_order[$];
    logic [7:0] exp_sum[N];
    int         checks = 0;
    int         errors = 0;
    int         rsp_seen = 0;
    logic       prev_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (add_en) chk("add_en_single_cycle", 32'(prev_en), 0);
            if (rsp_valid != 0) begin
                rsp_seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
                    chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                    chk("rsp_latency", cyc, e.due);
                end
            end
        end
        prev_en = add_en;
    end

    task automatic set_op(input int i, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] s);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        exp_sum[i] = s;
    endtask

    task automatic grant_seq(input int n, input bit drop_each,
                             input bit chk_gap);
        int  last;
        int  gi;
        bit  seen;
        last = 0;
        for (int k = 0; k < n; k++) begin
            seen = 1'b0;
            for (int t = 0; t < 40 && !seen; t++) begin
                @(negedge clk);
                if (req_ready != 0) seen = 1'b1;
            end
            if (!seen) begin
                chk("grant_timeout", 0, 1);
                break;
            end
            gi = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
            chk("grant_onehot", 32'($onehot(req_ready)), 1);
            chk("grant_idx", gi, exp_order[k]);
            if (chk_gap && k > 0) chk("grant_gap", cyc - last, 11);
            last = cyc;
            sb.push_back('{gi, exp_sum[gi], cyc + 11});
            @(posedge clk); #1;
            if (drop_each) req_valid[gi] = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 60 && sb.size() != 0; t++) @(negedge clk);
        chk("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int base;
    bit seen0;

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_sum", 32'(rsp_sum), 0);
        chk("rst_add_en", 32'(add_en), 0);
        chk("rst_add_a", 32'(add_a), 0);
        chk("rst_add_b", 32'(add_b), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;

        // Fairness: all four held high
        set_op(0, 8'h01, 8'h02, 8'h03);
        set_op(1, 8'h10, 8'h05, 8'h15);
        set_op(2, 8'h7F, 8'h01, 8'h80);
        set_op(3, 8'hC0, 8'h3F, 8'hFF);
        req_valid = 4'hF;
`ifdef ADD_SERIAL_ARB_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        grant_seq(5, 1'b0, 1'b1);
        req_valid = '0;
        wait_drain();

        // Single op, operands changed after accept
        set_op(0, 8'h35, 8'h4A, 8'h7F);
        req_valid[0] = 1'b1;
        exp_order = '{0};
        grant_seq(1, 1'b1, 1'b0);
        req_a[7:0] = 8'hEE;
        req_b[7:0] = 8'hEE;
        @(negedge clk);
        chk("load_add_en", 32'(add_en), 1);
        chk("load_add_a", 32'(add_a), 32'h35);
        chk("load_add_b", 32'(add_b), 32'h4A);
        @(negedge clk);
        chk("run_add_en", 32'(add_en), 0);
        chk("run_busy", 32'(busy), 1);
        wait_drain();
        @(negedge clk);
        chk("hold_rsp_sum", 32'(rsp_sum), 32'h7F);
        chk("hold_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;

        // Overflow wraps
        set_op(2, 8'hFF, 8'h01, 8'h00);
        req_valid[2] = 1'b1;
        exp_order = '{2};
        grant_seq(1, 1'b1, 1'b0);
        wait_drain();
        set_op(2, 8'h80, 8'h80, 8'h00);
        req_valid[2] = 1'b1;
        grant_seq(1, 1'b1, 1'b0);
        wait_drain();

        // Reset in RUN cycle 4 aborts silently
        set_op(0, 8'h11, 8'h22, 8'h33);
        req_valid[0] = 1'b1;
        seen0 = 1'b0;
        for (int t = 0; t < 40 && !seen0; t++) begin
            @(negedge clk);
            if (req_ready != 0) seen0 = 1'b1;
        end
        chk("abort_grant", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("abort_pre_busy", 32'(busy), 1);
        rst = 1'b1;
        base = rsp_seen;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_add_en", 32'(add_en), 0);
        repeat (15) @(negedge clk);
        chk("abort_no_rsp", rsp_seen - base, 0);
        @(posedge clk); #1;

        set_op(1, 8'h10, 8'h20, 8'h30);
        req_valid[1] = 1'b1;
        exp_order = '{1};
        grant_seq(1, 1'b1, 1'b0);
        wait_drain();

        // Two pending with pointer at 2
        set_op(1, 8'h01, 8'h01, 8'h02);
        set_op(3, 8'h40, 8'h02, 8'h42);
        req_valid = 4'b1010;
`ifdef ADD_SERIAL_ARB_PRIO_EN
        exp_order = '{1, 3};
`else
        exp_order = '{3, 1};
`endif
        grant_seq(2, 1'b1, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
